// File: rtl/fpga_cfg_loader.sv
// Purpose : serial configuration loader; shifts a bitstream into the CLB chain, then the connection chain.
// Latency : 3 clk per bit minimum (WAIT -> SETUP -> HIGH); DONE follows the HIGH phase of the last bit.
// Backpressure: cfg_ready only in WAIT; with cfg_valid low the loader stalls indefinitely with scan_clk low.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   cfg_start, cfg_abort             load request / abort of a load in progress
//   cfg_data, cfg_valid, cfg_ready   serial bitstream handshake (CLB bits first, then connection bits)
//   scan_clk                         registered scan clock to the core
//   clb_scan_in/_en, conn_scan_in/_en  chain data and enables
//   clb_scan_out, conn_scan_out      chain tails, captured for readback
//   rb_bit, rb_valid                 readback bit with one-cycle qualifier
//   cfg_busy, cfg_done, cfg_err, fpga_en  status
module fpga_cfg_loader #(
    parameter int CLB_LEN  = 2048,
    parameter int CONN_LEN = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic cfg_start,
    input  logic cfg_abort,
    input  logic cfg_data,
    input  logic cfg_valid,
    output logic cfg_ready,
    output logic scan_clk,
    output logic clb_scan_in,
    output logic clb_scan_en,
    output logic conn_scan_in,
    output logic conn_scan_en,
    input  logic clb_scan_out,
    input  logic conn_scan_out,
    output logic rb_bit,
    output logic rb_valid,
    output logic cfg_busy,
    output logic cfg_done,
    output logic cfg_err,
    output logic fpga_en
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CLB,
        ST_LOAD_CONN,
        ST_DONE,
        ST_ABORTED
    } state_t;

    typedef enum logic [1:0] {
        PH_WAIT,
        PH_SETUP,
        PH_HIGH
    } phase_t;

    // Counter holds the number of completed bits, so the last bit of a chain is LEN-1.
    localparam logic [15:0] CLB_LAST  = 16'(CLB_LEN - 1);
    localparam logic [15:0] CONN_LAST = 16'(CONN_LEN - 1);

    state_t      r_state;
    phase_t      r_phase;
    logic [15:0] r_cnt;
    logic        r_scan_clk;
    logic        r_clb_scan_in;
    logic        r_clb_scan_en;
    logic        r_conn_scan_in;
    logic        r_conn_scan_en;
    logic        r_rb_bit;
    logic        r_rb_valid;
    logic        r_cfg_busy;
    logic        r_cfg_done;
    logic        r_cfg_err;
    logic        r_fpga_en;

    logic        w_loading;
    logic        w_in_clb;

    assign w_loading = (r_state == ST_LOAD_CLB) || (r_state == ST_LOAD_CONN);
    assign w_in_clb  = (r_state == ST_LOAD_CLB);

    // Decoded from state registers only: no input reaches any output combinationally.
    assign cfg_ready    = w_loading && (r_phase == PH_WAIT);
    assign scan_clk     = r_scan_clk;
    assign clb_scan_in  = r_clb_scan_in;
    assign clb_scan_en  = r_clb_scan_en;
    assign conn_scan_in = r_conn_scan_in;
    assign conn_scan_en = r_conn_scan_en;
    assign rb_bit       = r_rb_bit;
    assign rb_valid     = r_rb_valid;
    assign cfg_busy     = r_cfg_busy;
    assign cfg_done     = r_cfg_done;
    assign cfg_err      = r_cfg_err;
    assign fpga_en      = r_fpga_en;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_phase        <= PH_WAIT;
            r_cnt          <= '0;
            r_scan_clk     <= 1'b0;
            r_clb_scan_in  <= 1'b0;
            r_clb_scan_en  <= 1'b0;
            r_conn_scan_in <= 1'b0;
            r_conn_scan_en <= 1'b0;
            r_rb_bit       <= 1'b0;
            r_rb_valid     <= 1'b0;
            r_cfg_busy     <= 1'b0;
            r_cfg_done     <= 1'b0;
            r_cfg_err      <= 1'b0;
            r_fpga_en      <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ABORTED: begin
                    // Abort is ignored here, so start alone decides.
                    if (cfg_start) begin
                        r_state        <= ST_LOAD_CLB;
                        r_phase        <= PH_WAIT;
                        r_cnt          <= '0;
                        r_scan_clk     <= 1'b0;
                        r_clb_scan_in  <= 1'b0;
                        r_clb_scan_en  <= 1'b1;
                        r_conn_scan_in <= 1'b0;
                        r_conn_scan_en <= 1'b0;
                        r_cfg_busy     <= 1'b1;
                        r_cfg_done     <= 1'b0;
                        r_cfg_err      <= 1'b0;
                        r_fpga_en      <= 1'b0;
                    end
                end
                ST_LOAD_CLB, ST_LOAD_CONN: begin
                    if (cfg_abort) begin
                        // Any partial bit (including one in HIGH) is dropped.
                        r_state        <= ST_ABORTED;
                        r_phase        <= PH_WAIT;
                        r_scan_clk     <= 1'b0;
                        r_clb_scan_in  <= 1'b0;
                        r_clb_scan_en  <= 1'b0;
                        r_conn_scan_in <= 1'b0;
                        r_conn_scan_en <= 1'b0;
                        r_cfg_busy     <= 1'b0;
                        r_cfg_err      <= 1'b1;
                        r_fpga_en      <= 1'b0;
                    end else begin
                        case (r_phase)
                            PH_WAIT: begin
                                if (cfg_valid) begin
                                    r_phase <= PH_SETUP;
                                    if (w_in_clb) r_clb_scan_in  <= cfg_data;
                                    else          r_conn_scan_in <= cfg_data;
                                end
                            end
                            PH_SETUP: begin
                                // Tail is sampled before this bit's rising scan_clk shifts the chain.
                                r_phase    <= PH_HIGH;
                                r_scan_clk <= 1'b1;
                                r_rb_bit   <= w_in_clb ? clb_scan_out : conn_scan_out;
                                r_rb_valid <= 1'b1;
                            end
                            default: begin
                                r_phase    <= PH_WAIT;
                                r_scan_clk <= 1'b0;
                                if (w_in_clb) begin
                                    if (r_cnt == CLB_LAST) begin
                                        r_state        <= ST_LOAD_CONN;
                                        r_cnt          <= '0;
                                        r_clb_scan_en  <= 1'b0;
                                        r_clb_scan_in  <= 1'b0;
                                        r_conn_scan_en <= 1'b1;
                                    end else begin
                                        r_cnt <= r_cnt + 16'd1;
                                    end
                                end else begin
                                    if (r_cnt == CONN_LAST) begin
                                        r_state        <= ST_DONE;
                                        r_conn_scan_en <= 1'b0;
                                        r_conn_scan_in <= 1'b0;
                                        r_cfg_busy     <= 1'b0;
                                        r_cfg_done     <= 1'b1;
                                        r_fpga_en      <= 1'b1;
                                    end else begin
                                        r_cnt <= r_cnt + 16'd1;
                                    end
                                end
                            end
                        endcase
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_phase <= PH_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
module tb_fpga_cfg_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cfg_start = 1'b0;
    logic cfg_abort = 1'b0;
    logic cfg_data = 1'b0;
    logic cfg_valid = 1'b0;
    logic cfg_ready, scan_clk, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en;
    logic clb_scan_out, conn_scan_out, rb_bit, rb_valid;
    logic cfg_busy, cfg_done, cfg_err, fpga_en;

    int n_tests = 0;
    int n_fail  = 0;
    int n_sclk  = 0;
    int n_acc   = 0;

    fpga_cfg_loader #(.CLB_LEN(4), .CONN_LEN(3)) dut (
        .clk(clk), .rst(rst),
        .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .scan_clk(scan_clk),
        .clb_scan_in(clb_scan_in), .clb_scan_en(clb_scan_en),
        .conn_scan_in(conn_scan_in), .conn_scan_en(conn_scan_en),
        .clb_scan_out(clb_scan_out), .conn_scan_out(conn_scan_out),
        .rb_bit(rb_bit), .rb_valid(rb_valid),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err), .fpga_en(fpga_en)
    );

    always #5 clk = ~clk;

    // Chain models: shift on rising scan_clk when enabled; tail is the bit shifted in LEN pulses earlier.
    logic [3:0] clb_chain  = '0;
    logic [2:0] conn_chain = '0;
    assign clb_scan_out  = clb_chain[3];
    assign conn_scan_out = conn_chain[2];
    always @(posedge scan_clk) begin
        if (clb_scan_en)  clb_chain  <= {clb_chain[2:0], clb_scan_in};
        if (conn_scan_en) conn_chain <= {conn_chain[1:0], conn_scan_in};
        n_sclk++;
    end

    always @(posedge clk) begin
        if (!rst && cfg_ready && cfg_valid) n_acc++;
    end

    typedef struct {
        logic d;
        logic exp_clb_in;
        logic exp_clb_en;
        logic exp_conn_in;
        logic exp_conn_en;
    } vec_t;
    vec_t vecs [7];

    function automatic logic [11:0] all_outs();
        return {cfg_ready, scan_clk, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en,
                rb_bit, rb_valid, cfg_busy, cfg_done, cfg_err, fpga_en};
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in LOAD_CLB/WAIT with cfg_valid already high; leaves the DUT in DONE.
    task automatic run_load(input bit check_rb, input bit stall, input bit repulse);
        int sclk0, acc0;
        sclk0 = n_sclk;
        acc0  = n_acc;
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("wait_ready[%0d]", i), 16'(cfg_ready), 16'd1);
            chk($sformatf("wait_sclk[%0d]", i), 16'(scan_clk), 16'd0);
            if (stall && i == 2) begin
                cfg_valid = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    chk("stall_ready", 16'(cfg_ready), 16'd1);
                    chk("stall_sclk", 16'(scan_clk), 16'd0);
                    chk("stall_hold_in", 16'(clb_scan_in), 16'(vecs[1].d));
                end
                cfg_valid = 1'b1;
            end
            cfg_data = vecs[i].d;
            if (repulse && i == 3) cfg_start = 1'b1;
            tick();
            cfg_start = 1'b0;
            // SETUP
            chk($sformatf("setup_vec[%0d]", i),
                16'({scan_clk, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en, cfg_ready, rb_valid, cfg_busy}),
                16'({1'b0, vecs[i].exp_clb_in, vecs[i].exp_clb_en, vecs[i].exp_conn_in,
                     vecs[i].exp_conn_en, 1'b0, 1'b0, 1'b1}));
            tick();
            // HIGH
            chk($sformatf("high_sclk[%0d]", i), 16'(scan_clk), 16'd1);
            chk($sformatf("high_rbv[%0d]", i), 16'(rb_valid), 16'd1);
            chk($sformatf("high_done[%0d]", i), 16'(cfg_done), 16'd0);
            if (check_rb)
                chk($sformatf("rb_bit[%0d]", i), 16'(rb_bit), 16'(vecs[i].d));
            tick();
        end
        chk("done_flags", 16'({cfg_done, fpga_en, cfg_busy, cfg_err}), 16'b1100);
        chk("done_scan", 16'({scan_clk, clb_scan_en, conn_scan_en, cfg_ready, rb_valid}), 16'd0);
        chk("sclk_pulses", 16'(n_sclk - sclk0), 16'd7);
        chk("accepts", 16'(n_acc - acc0), 16'd7);
    endtask

    initial begin
        logic [6:0] pat;
        pat = 7'b1011010;   // bits 1..7 in order, MSB first
        for (int i = 0; i < 7; i++) begin
            vecs[i].d           = pat[6 - i];
            vecs[i].exp_clb_en  = (i < 4);
            vecs[i].exp_conn_en = (i >= 4);
            vecs[i].exp_clb_in  = (i < 4)  ? pat[6 - i] : 1'b0;
            vecs[i].exp_conn_in = (i >= 4) ? pat[6 - i] : 1'b0;
        end

        // Reset state
        tick();
        tick();
        chk("reset_outs", 16'(all_outs()), 16'd0);
        rst = 1'b0;
        tick();
        chk("idle_outs", 16'(all_outs()), 16'd0);

        // Pass 1: chains start at zero, so readback is all zero
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("start_busy", 16'({cfg_busy, clb_scan_en, cfg_ready}), 16'b111);
        for (int i = 0; i < 7; i++) vecs[i].d = vecs[i].d;
        run_load(1'b0, 1'b0, 1'b0);

        // Pass 2: stall after bit 2, start re-pulsed mid-load; readback returns pass-1 data
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("restart_done_clr", 16'({cfg_done, fpga_en, cfg_busy}), 16'b001);
        run_load(1'b1, 1'b1, 1'b1);

        // Abort during HIGH of connection bit 2, together with start (abort wins)
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cfg_data = vecs[i].d;
            tick(); tick(); tick();
        end
        cfg_data = vecs[5].d;
        tick(); tick();
        chk("abort_in_high", 16'({scan_clk, conn_scan_en}), 16'b11);
        cfg_abort = 1'b1;
        cfg_start = 1'b1;
        tick();
        cfg_abort = 1'b0;
        cfg_start = 1'b0;
        chk("aborted_flags", 16'({cfg_err, fpga_en, cfg_busy, cfg_done}), 16'b1000);
        chk("aborted_scan", 16'({scan_clk, clb_scan_en, conn_scan_en, clb_scan_in, conn_scan_in, cfg_ready}), 16'd0);
        cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        chk("abort_ignored", 16'({cfg_err, cfg_busy}), 16'b10);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("restart_after_abort", 16'({cfg_err, cfg_busy, clb_scan_en, conn_scan_en}), 16'b0110);
        run_load(1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a HIGH phase
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_data = 1'b1;
        tick(); tick();
        chk("pre_rst_high", 16'(scan_clk), 16'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_outs", 16'(all_outs()), 16'd0);
        tick();
        tick();
        chk("held_rst_outs", 16'(all_outs()), 16'd0);
        rst = 1'b0;
        cfg_valid = 1'b0;
        tick();
        chk("post_rst_idle", 16'(all_outs()), 16'd0);

        // Start and abort together while idle: start wins
        cfg_start = 1'b1;
        cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        chk("start_abort_idle", 16'({cfg_busy, clb_scan_en, cfg_err, cfg_ready}), 16'b1101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fpga_cfg_loader.md
FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

Interface
REQ-001 Parameter: CLB_LEN, default 2048, number of bits in the CLB scan chain; legal range 1..65535.
REQ-002 Parameter: CONN_LEN, default 4096, number of bits in the connection scan chain; legal range 1..65535.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; asynchronous and active-high.
REQ-005 cfg_start  input  1  one-cycle request to begin loading the configuration.
REQ-006 cfg_abort  input  1  abort of an in-progress load.
REQ-007 cfg_data  input  1  serial bitstream bit; all CLB_LEN CLB bits first, then all CONN_LEN connection bits.
REQ-008 cfg_valid  input  1  cfg_data is valid.
REQ-009 cfg_ready  output  1  loader accepts cfg_data this cycle.
REQ-010 scan_clk  output  1  registered scan clock driven to the core.
REQ-011 clb_scan_in / clb_scan_en  output  1 each  CLB chain data and enable.
REQ-012 conn_scan_in / conn_scan_en  output  1 each  connection chain data and enable.
REQ-013 clb_scan_out / conn_scan_out  input  1 each  chain tail bits, used for readback.
REQ-014 rb_bit / rb_valid  output  1 each  readback bit and its one-cycle qualifier.
REQ-015 cfg_busy, cfg_done, cfg_err, fpga_en  output  1 each  status flags.

Function
REQ-016 The loader SHALL have five states: IDLE, LOAD_CLB, LOAD_CONN, DONE and ABORTED.
REQ-017 Each state from LOAD_CLB onward SHALL sequence every bit through three phases: WAIT, SETUP and HIGH.
REQ-018 cfg_ready SHALL be 1 only in phase WAIT of LOAD_CLB or LOAD_CONN.
REQ-019 A bit SHALL be accepted in any cycle where cfg_valid=1 and cfg_ready=1.
REQ-020 When cfg_valid=0 in WAIT, the loader SHALL stall indefinitely with scan_clk=0 and outputs held.
REQ-021 At the edge after acceptance (entry to SETUP), the active chain's scan_in SHALL be registered to cfg_data while scan_clk stays 0.
REQ-022 At the next edge (entry to HIGH), scan_clk SHALL go to 1.
REQ-023 At the following edge, scan_clk SHALL return to 0, the bit counter SHALL increment, and the phase SHALL return to WAIT.
REQ-024 The minimum throughput SHALL be 3 clk cycles per bit.
REQ-025 At the edge that enters HIGH, the loader SHALL register rb_bit from the active chain's scan_out and pulse rb_valid=1 for one cycle.
REQ-026 clb_scan_en SHALL be 1 throughout LOAD_CLB and 0 otherwise.
REQ-027 conn_scan_en SHALL be 1 throughout LOAD_CONN and 0 otherwise.
REQ-028 The inactive chain's scan_in SHALL be held at 0.
REQ-029 cfg_start while IDLE, DONE or ABORTED SHALL move to LOAD_CLB at the next edge, with the counter and cfg_err cleared and cfg_done cleared.
REQ-030 cfg_start while in LOAD_CLB or LOAD_CONN SHALL be ignored.
REQ-031 After the HIGH phase of CLB bit CLB_LEN, the loader SHALL enter LOAD_CONN in WAIT with the counter reset to 0.
REQ-032 After the HIGH phase of connection bit CONN_LEN, the loader SHALL enter DONE.
REQ-033 The bit counter SHALL be 16 bits wide and SHALL never wrap; terminal counts are compared exactly.
REQ-034 In DONE: cfg_done=1, fpga_en=1, scan_clk=0 and both scan enables are 0.
REQ-035 cfg_abort in LOAD_CLB or LOAD_CONN, in any phase, SHALL enter ABORTED at the next edge.
REQ-036 In ABORTED: cfg_err=1, fpga_en=0, scan_clk=0, enables are 0 and scan_in values are 0.
REQ-037 If a HIGH phase is cut short by an abort, that bit SHALL be discarded.
REQ-038 cfg_abort in IDLE, DONE or ABORTED SHALL be ignored.
REQ-039 If cfg_abort and cfg_start are asserted together, cfg_abort SHALL win during a load, and cfg_start SHALL win otherwise.
REQ-040 cfg_busy SHALL be 1 exactly in LOAD_CLB and LOAD_CONN.
REQ-041 Every output SHALL be driven directly from a flop, with no combinational path from input to output; cfg_ready is the sole exception and is decoded from state only.

Reset
REQ-042 While rst=1, and immediately on its assertion, the loader SHALL be in IDLE, phase WAIT, with counter=0.
REQ-043 Under reset, every output SHALL be 0: cfg_ready, scan_clk, both scan_in and scan_en pairs, rb_bit, rb_valid, cfg_busy, cfg_done, cfg_err and fpga_en.
REQ-044 A reset asserted mid-load SHALL discard all progress; a new cfg_start SHALL be required afterwards.

Verification (CLB_LEN=4, CONN_LEN=3)
REQ-045 Stimulus: start, then cfg_valid held 1 with bits 1,0,1,1,0,1,0.
Required response: 7 accepts spaced 3 cycles apart, and 7 scan_clk pulses.
Required response: clb_scan_in sequence 1,0,1,1 with clb_scan_en=1, followed by conn_scan_in sequence 0,1,0 with conn_scan_en=1.
Required response: DONE at 21 cycles after start, with fpga_en=1.
REQ-046 Stimulus: drop cfg_valid for 5 cycles after bit 2.
Required response: cfg_ready stays 1, scan_clk stays 0 and the counter holds; the load then completes with an identical chain bit order.
REQ-047 Stimulus: cfg_abort during the HIGH phase of connection bit 2.
Required response: next cycle cfg_err=1, scan_clk=0, both enables 0 and fpga_en=0; a following cfg_start restarts from CLB bit 1.
REQ-048 Stimulus: cfg_start re-pulsed mid-load.
Required response: no effect.
Stimulus: cfg_start and cfg_abort together in IDLE.
Required response: LOAD_CLB is entered.
REQ-049 Stimulus: chain model returns the shifted-in bits delayed by chain length.
Required response: rb_valid pulses once per bit, and rb_bit matches the model.
REQ-050 Stimulus: rst asserted asynchronously mid-HIGH.
Required response: scan_clk falls to 0 without waiting for a clock edge, all outputs are 0, and the loader is IDLE after rst is released.
